cache_miss_handler: RTL

Sequencing controller that sits between the CPU-side request stream and the direct-mapped L1 tag cache (16384 indices, index = addr[13:0], tag = addr[31:14]). It initiates cache lookups, and on a miss requests the line from backing memory. After the memory acknowledges, it issues the fill write into the cache and returns a hit/miss/error response to the requester. It also keeps saturating hit and miss statistics.

---
 rtl/cache_miss_handler_if.sv | 38 +++
 rtl/cache_miss_handler.sv | 112 +++++++++++
 2 files changed

// File: rtl/cache_miss_handler_if.sv
// Bundles the CPU request/response, cache lookup/fill and memory fetch signals
// of the cache miss handler. The handler connects through the master modport.
interface cache_miss_handler_if #(
    parameter int CNT_W = 16
);
    logic             cpu_valid;
    logic [31:0]      cpu_addr;
    logic             cpu_ready;

    logic             resp_valid;
    logic             resp_hit;
    logic             resp_err;
    logic [31:0]      resp_addr;

    logic [31:0]      c_addr;
    logic             c_we;
    logic             c_oe;
    logic             c_found;

    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;

    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        input  cpu_valid, cpu_addr, c_found, mem_ack,
        output cpu_ready, resp_valid, resp_hit, resp_err, resp_addr,
        output c_addr, c_we, c_oe, mem_req, mem_addr, hit_count, miss_count
    );

    modport slave (
        output cpu_valid, cpu_addr, c_found, mem_ack,
        input  cpu_ready, resp_valid, resp_hit, resp_err, resp_addr,
        input  c_addr, c_we, c_oe, mem_req, mem_addr, hit_count, miss_count
    );
endinterface

// File: rtl/cache_miss_handler.sv
// Sequences one CPU request at a time through tag lookup, memory fetch on miss,
// cache fill and response, keeping saturating hit/miss statistics.
module cache_miss_handler #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_miss_handler_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_FILL,
        S_RESP
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;
    logic [15:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
            tmr_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hit_q      <= hit_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hit_d      = hit_q;
        err_d      = err_q;
        tmr_d      = tmr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_valid) begin
                    addr_d  = bus.cpu_addr;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (bus.c_found) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                    hit_d     = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    tmr_d      = '0;
                    state_d    = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                // An ack on the expiry edge still counts as a successful fetch.
                if (bus.mem_ack) begin
                    state_d = S_FILL;
                end else if (tmr_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            S_FILL: state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Every output decodes from registered state, so none is combinational on inputs.
    assign bus.cpu_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_hit   = hit_q;
    assign bus.resp_err   = err_q;
    assign bus.resp_addr  = addr_q;
    assign bus.c_addr     = addr_q;
    assign bus.c_oe       = (state_q == S_LOOKUP);
    assign bus.c_we       = (state_q == S_FILL);
    assign bus.mem_req    = (state_q == S_MISS_REQ);
    assign bus.mem_addr   = addr_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule
